// File: rtl/rid_sequencer.sv
// rid_sequencer
// Read-response sequencer between the read-ID FIFO and the AXI R channel.
// Pops one {id, len} entry per burst, buffers PHY read beats (which cannot be
// stalled) in a circular buffer, and presents them on AXI R with beat
// counting, rlast generation and a sticky overflow flag.
//
// Optional build macro: RID_SEQ_STALL_CNT_EN
//   defined   : stall_cnt counts cycles with rvalid && !rready (saturating)
//   undefined : stall_cnt is tied to 0
//
// Ports
//   clk, n_rst             clock, asynchronous active-low reset
//   rid_empty, rid_rdata   read-ID FIFO head (first-word-fall-through)
//   rid_pop                consume FIFO head at this posedge
//   dfi_rvalid, dfi_rdata  PHY read beat, no backpressure
//   rvalid, rready         AXI R handshake
//   rid, rdata, rlast      AXI R payload, 0 while rvalid is low
//   buf_overflow           sticky, a PHY beat was dropped
//   stall_cnt              R-channel stall counter
//
// state | meaning
// IDLE  | no burst active; pop the next ID entry as soon as one is visible
// BURST | delivering beats of cur_id; last handshake reloads or returns IDLE
module rid_sequencer #(
  parameter int ID_W      = 4,
  parameter int LEN_W     = 8,
  parameter int DATA_W    = 64,
  parameter int BUF_DEPTH = 8
) (
  input  logic                   clk,
  input  logic                   n_rst,
  input  logic                   rid_empty,
  input  logic [ID_W+LEN_W-1:0]  rid_rdata,
  output logic                   rid_pop,
  input  logic                   dfi_rvalid,
  input  logic [DATA_W-1:0]      dfi_rdata,
  output logic                   rvalid,
  input  logic                   rready,
  output logic [ID_W-1:0]        rid,
  output logic [DATA_W-1:0]      rdata,
  output logic                   rlast,
  output logic                   buf_overflow,
  output logic [15:0]            stall_cnt
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  typedef enum logic {IDLE, BURST} state_t;

  state_t             state, state_nxt;
  logic [ID_W-1:0]    cur_id;
  logic [LEN_W-1:0]   cur_len;
  logic [LEN_W-1:0]   beat_cnt;
  logic [DATA_W-1:0]  mem [BUF_DEPTH];
  logic [PTR_W-1:0]   rd_ptr, wr_ptr;
  logic [CNT_W-1:0]   count;
  logic               hs, last_beat, buf_full, wr_en, load;

  assign last_beat = (beat_cnt == cur_len);
  assign buf_full  = (count == CNT_W'(BUF_DEPTH));
  assign hs        = rvalid && rready;
  // A full buffer still accepts a beat when the head leaves at the same edge.
  assign wr_en     = dfi_rvalid && (!buf_full || hs);

  always_comb begin
    state_nxt = state;
    rid_pop   = 1'b0;
    load      = 1'b0;
    rvalid    = (state == BURST) && (count != '0);
    case (state)
      IDLE: begin
        if (!rid_empty) begin
          rid_pop   = 1'b1;
          load      = 1'b1;
          state_nxt = BURST;
        end
      end
      BURST: begin
        if (rvalid && rready && last_beat) begin
          if (!rid_empty) begin
            rid_pop = 1'b1;
            load    = 1'b1;
          end else begin
            state_nxt = IDLE;
          end
        end
      end
      default: state_nxt = IDLE;
    endcase
    rid   = rvalid ? cur_id : '0;
    rdata = rvalid ? mem[rd_ptr] : '0;
    rlast = rvalid && last_beat;
  end

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst) begin
      state        <= IDLE;
      cur_id       <= '0;
      cur_len      <= '0;
      beat_cnt     <= '0;
      rd_ptr       <= '0;
      wr_ptr       <= '0;
      count        <= '0;
      buf_overflow <= 1'b0;
    end else begin
      state <= state_nxt;
      if (load) begin
        cur_id   <= rid_rdata[ID_W+LEN_W-1:LEN_W];
        cur_len  <= rid_rdata[LEN_W-1:0];
        beat_cnt <= '0;
      end else if (hs) begin
        beat_cnt <= beat_cnt + LEN_W'(1);
      end
      if (hs)
        rd_ptr <= rd_ptr + PTR_W'(1);
      if (wr_en)
        wr_ptr <= wr_ptr + PTR_W'(1);
      count <= count + CNT_W'(wr_en) - CNT_W'(hs);
      if (dfi_rvalid && buf_full && !hs)
        buf_overflow <= 1'b1;
    end
  end

  // Data storage needs no reset: the head is only visible while count != 0.
  always_ff @(posedge clk) begin
    if (wr_en)
      mem[wr_ptr] <= dfi_rdata;
  end

`ifdef RID_SEQ_STALL_CNT_EN
  logic [15:0] stall_q;

  always_ff @(posedge clk or negedge n_rst) begin
    if (!n_rst)
      stall_q <= '0;
    else if (rvalid && !rready && (stall_q != 16'hFFFF))
      stall_q <= stall_q + 16'd1;
  end

  assign stall_cnt = stall_q;
`else
  assign stall_cnt = '0;
`endif

endmodule

// File: tb/tb_rid_sequencer.sv
module tb_rid_sequencer;

  logic        clk = 1'b0;
  logic        n_rst = 1'b1;
  logic        rid_empty = 1'b1;
  logic [11:0] rid_rdata = '0;
  logic        rid_pop;
  logic        dfi_rvalid = 1'b0;
  logic [63:0] dfi_rdata = '0;
  logic        rvalid;
  logic        rready = 1'b0;
  logic [3:0]  rid;
  logic [63:0] rdata;
  logic        rlast;
  logic        buf_overflow;
  logic [15:0] stall_cnt;

  int checks = 0;
  int failures = 0;

  logic [11:0] q [$];

  logic        o_pop, o_rv, o_last, o_ovf;
  logic [3:0]  o_rid;
  logic [63:0] o_data;
  logic [15:0] o_stall;

  logic        e_pop, e_rv, e_last, e_ovf;
  logic [3:0]  e_rid;
  logic [63:0] e_data;

  int bp_idx [17] = '{0, 0, 0, 1, 2, 2, 2, 3, 4, 4, 4, 5, 6, 6, 6, 7, 0};

`ifdef RID_SEQ_STALL_CNT_EN
  localparam logic [15:0] EXP_STALL = 16'd7;
`else
  localparam logic [15:0] EXP_STALL = 16'd0;
`endif

  rid_sequencer #(.ID_W(4), .LEN_W(8), .DATA_W(64), .BUF_DEPTH(8)) dut (
    .clk          (clk),
    .n_rst        (n_rst),
    .rid_empty    (rid_empty),
    .rid_rdata    (rid_rdata),
    .rid_pop      (rid_pop),
    .dfi_rvalid   (dfi_rvalid),
    .dfi_rdata    (dfi_rdata),
    .rvalid       (rvalid),
    .rready       (rready),
    .rid          (rid),
    .rdata        (rdata),
    .rlast        (rlast),
    .buf_overflow (buf_overflow),
    .stall_cnt    (stall_cnt)
  );

  always #5 clk = ~clk;

  // One clock cycle: drive at negedge from the FIFO model, sample 1 ns later,
  // then let the posedge happen and consume the FIFO head if it was popped.
  task automatic cyc(input logic dv, input logic [63:0] d, input logic rr);
    @(negedge clk);
    rid_empty  = (q.size() == 0);
    rid_rdata  = (q.size() != 0) ? q[0] : 12'h000;
    dfi_rvalid = dv;
    dfi_rdata  = d;
    rready     = rr;
    #1;
    o_pop   = rid_pop;
    o_rv    = rvalid;
    o_last  = rlast;
    o_ovf   = buf_overflow;
    o_rid   = rid;
    o_data  = rdata;
    o_stall = stall_cnt;
    @(posedge clk);
    if (o_pop && (q.size() != 0))
      void'(q.pop_front());
  endtask

  task automatic do_reset();
    @(negedge clk);
    n_rst = 1'b0;
    q.delete();
    rid_empty  = 1'b1;
    rid_rdata  = '0;
    dfi_rvalid = 1'b0;
    dfi_rdata  = '0;
    rready     = 1'b0;
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_reset();
    n_rst = 1'b1;
    #3;
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rid_pop, rvalid, rlast, buf_overflow, rid, rdata, stall_cnt} !== 88'd0) begin
      failures++;
      $display("FAIL reset_outputs got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h stall=%0d exp all 0",
               rid_pop, rvalid, rlast, buf_overflow, rid, rdata, stall_cnt);
    end
    @(negedge clk);
    @(negedge clk);
    n_rst = 1'b1;
  endtask

  task automatic test_single_burst();
    q.push_back({4'd3, 8'd3});
    for (int i = 0; i < 6; i++) begin
      cyc(i < 4, 64'hA0 + 64'(i), 1'b1);
      e_pop  = (i == 0);
      e_rv   = (i >= 1) && (i <= 4);
      e_last = (i == 4);
      e_ovf  = 1'b0;
      e_rid  = e_rv ? 4'd3 : 4'd0;
      e_data = e_rv ? 64'hA0 + 64'(i - 1) : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL single_burst cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  task automatic test_back_to_back();
    q.push_back({4'd1, 8'd0});
    q.push_back({4'd2, 8'd1});
    for (int i = 0; i < 5; i++) begin
      cyc(i < 3, 64'hB0 + 64'(i), 1'b1);
      e_pop  = (i <= 1);
      e_rv   = (i >= 1) && (i <= 3);
      e_last = (i == 1) || (i == 3);
      e_ovf  = 1'b0;
      e_rid  = (i == 1) ? 4'd1 : (e_rv ? 4'd2 : 4'd0);
      e_data = e_rv ? 64'hB0 + 64'(i - 1) : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL back_to_back cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  task automatic test_backpressure();
    q.push_back({4'd5, 8'd7});
    for (int i = 0; i < 17; i++) begin
      cyc(i < 8, 64'hC0 + 64'(i), ((i / 2) % 2) == 1);
      e_pop  = (i == 0);
      e_rv   = (i >= 1) && (i <= 15);
      e_last = (i == 15);
      e_ovf  = 1'b0;
      e_rid  = e_rv ? 4'd5 : 4'd0;
      e_data = e_rv ? 64'hC0 + 64'(bp_idx[i]) : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL backpressure cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
    checks++;
    if (o_stall !== EXP_STALL) begin
      failures++;
      $display("FAIL stall_cnt got %0d exp %0d", o_stall, EXP_STALL);
    end
  endtask

  task automatic test_early_data();
    for (int i = 0; i < 10; i++) begin
      if (i == 4)
        q.push_back({4'd0, 8'd3});
      cyc(i < 4, 64'hD0 + 64'(i), 1'b1);
      e_pop  = (i == 4);
      e_rv   = (i >= 5) && (i <= 8);
      e_last = (i == 8);
      e_ovf  = 1'b0;
      e_rid  = 4'd0;
      e_data = e_rv ? 64'hD0 + 64'(i - 5) : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL early_data cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  // Buffer filled to 8 in IDLE, then a 9th beat arrives on the first handshake.
  task automatic test_full_rw();
    for (int i = 0; i < 19; i++) begin
      if (i == 8) begin
        q.push_back({4'd6, 8'd7});
        q.push_back({4'd7, 8'd0});
      end
      cyc((i < 8) || (i == 9), (i < 8) ? 64'hF0 + 64'(i) : 64'hF8, 1'b1);
      e_pop  = (i == 8) || (i == 16);
      e_rv   = (i >= 9) && (i <= 17);
      e_last = (i == 16) || (i == 17);
      e_ovf  = 1'b0;
      e_rid  = (i == 17) ? 4'd7 : (e_rv ? 4'd6 : 4'd0);
      e_data = (i == 17) ? 64'hF8 : (e_rv ? 64'hF0 + 64'(i - 9) : 64'd0);
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL full_rw cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  task automatic test_overflow();
    for (int i = 0; i < 19; i++) begin
      if (i == 9)
        q.push_back({4'd4, 8'd7});
      cyc(i < 9, 64'h100 + 64'(i), i >= 9);
      e_pop  = (i == 9);
      e_rv   = (i >= 10) && (i <= 17);
      e_last = (i == 17);
      e_ovf  = (i >= 9);
      e_rid  = e_rv ? 4'd4 : 4'd0;
      e_data = e_rv ? 64'h100 + 64'(i - 10) : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL overflow cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  task automatic test_reset_mid_burst();
    do_reset();
    q.push_back({4'd9, 8'd3});
    for (int i = 0; i < 3; i++) begin
      cyc(1'b1, 64'h200 + 64'(i), 1'b1);
      e_rv   = (i >= 1);
      e_data = e_rv ? 64'h200 + 64'(i - 1) : 64'd0;
      e_rid  = e_rv ? 4'd9 : 4'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_rid, o_data} !== {(i == 0), e_rv, 1'b0, e_rid, e_data}) begin
        failures++;
        $display("FAIL mid_burst_pre cyc=%0d got pop=%b rv=%b last=%b rid=%h data=%h exp rv=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_rid, o_data, e_rv, e_rid, e_data);
      end
    end
    @(negedge clk);
    rid_empty  = 1'b1;
    dfi_rvalid = 1'b0;
    rready     = 1'b1;
    #1;
    checks++;
    if ({rvalid, rdata} !== {1'b1, 64'h202}) begin
      failures++;
      $display("FAIL mid_burst_head got rv=%b data=%h exp rv=1 data=202", rvalid, rdata);
    end
    n_rst = 1'b0;
    #1;
    checks++;
    if ({rid_pop, rvalid, rlast, buf_overflow, rid, rdata, stall_cnt} !== 88'd0) begin
      failures++;
      $display("FAIL mid_burst_reset got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h stall=%0d exp all 0",
               rid_pop, rvalid, rlast, buf_overflow, rid, rdata, stall_cnt);
    end
    @(negedge clk);
    n_rst = 1'b1;
    for (int i = 0; i < 6; i++) begin
      if (i == 1)
        q.push_back({4'd9, 8'd0});
      cyc(i == 3, 64'h2AA, 1'b1);
      e_pop  = (i == 1);
      e_rv   = (i == 4);
      e_last = (i == 4);
      e_ovf  = 1'b0;
      e_rid  = e_rv ? 4'd9 : 4'd0;
      e_data = e_rv ? 64'h2AA : 64'd0;
      checks++;
      if ({o_pop, o_rv, o_last, o_ovf, o_rid, o_data} !== {e_pop, e_rv, e_last, e_ovf, e_rid, e_data}) begin
        failures++;
        $display("FAIL mid_burst_post cyc=%0d got pop=%b rv=%b last=%b ovf=%b rid=%h data=%h exp pop=%b rv=%b last=%b ovf=%b rid=%h data=%h",
                 i, o_pop, o_rv, o_last, o_ovf, o_rid, o_data, e_pop, e_rv, e_last, e_ovf, e_rid, e_data);
      end
    end
  endtask

  initial begin
    test_reset();
    test_single_burst();
    test_back_to_back();
    test_backpressure();
    test_early_data();
    test_full_rw();
    test_overflow();
    test_reset_mid_burst();
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
